// File: rtl/tmds_video_pkg.sv
// Shared 800x600@60 timing constants, counter widths and sequencer state type
// for the TMDS video path.
package tmds_video_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam logic        SYNC_POL  = 1'b1;
    localparam logic [23:0] BLANK_RGB = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/video_timing_counter.sv
// Free-running H/V raster counters with active-region and sync decode.
// Counters sit at (0,0) whenever count_en is low.
module video_timing_counter
    import tmds_video_pkg::*;
#(
    parameter int H_ACTIVE = tmds_video_pkg::H_ACTIVE,
    parameter int H_FP     = tmds_video_pkg::H_FP,
    parameter int H_SYNC   = tmds_video_pkg::H_SYNC,
    parameter int H_BP     = tmds_video_pkg::H_BP,
    parameter int V_ACTIVE = tmds_video_pkg::V_ACTIVE,
    parameter int V_FP     = tmds_video_pkg::V_FP,
    parameter int V_SYNC   = tmds_video_pkg::V_SYNC,
    parameter int V_BP     = tmds_video_pkg::V_BP
) (
    input  logic           pixclk,
    input  logic           rst_n,
    input  logic           count_en,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           active,
    output logic           hsync_raw,
    output logic           vsync_raw,
    output logic           at_origin,
    output logic           at_last
);

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!count_en) begin
            x_d = '0;
            y_d = '0;
        end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
            x_d = x_q + 1'b1;
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign active    = (x_q < X_ACT) && (y_q < Y_ACT);
    assign hsync_raw = (x_q >= HS_START && x_q < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw = (y_q >= VS_START && y_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign at_origin = (x_q == '0) && (y_q == '0);
    assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/tmds_video_sequencer.sv
// Video timing sequencer feeding the TMDS encoders: run/drain control, pixel
// handshake toward the source, and one-cycle registered video outputs.
//
// state    | meaning
// ST_IDLE  | counters parked at (0,0), outputs blanked
// ST_RUN   | raster running, enable high
// ST_DRAIN | enable dropped, finishing the current frame
module tmds_video_sequencer
    import tmds_video_pkg::*;
#(
    parameter int H_ACTIVE = tmds_video_pkg::H_ACTIVE,
    parameter int H_FP     = tmds_video_pkg::H_FP,
    parameter int H_SYNC   = tmds_video_pkg::H_SYNC,
    parameter int H_BP     = tmds_video_pkg::H_BP,
    parameter int V_ACTIVE = tmds_video_pkg::V_ACTIVE,
    parameter int V_FP     = tmds_video_pkg::V_FP,
    parameter int V_SYNC   = tmds_video_pkg::V_SYNC,
    parameter int V_BP     = tmds_video_pkg::V_BP
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        vde,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        underflow,
    output logic        busy
);

    seq_state_e  state_q, state_d;
    logic        vde_q, vde_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d;
    logic [23:0] rgb_q, rgb_d;

    logic active, hsync_raw, vsync_raw, at_origin, at_last;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .pixclk    (pixclk),
        .rst_n     (rst_n),
        .count_en  (busy),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .active    (active),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .at_origin (at_origin),
        .at_last   (at_last)
    );

    assign busy      = (state_q != ST_IDLE);
    assign pix_ready = busy && active;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)       state_d = ST_RUN;
                else if (at_last) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Underflow is cleared on entry to IDLE so the first idle cycle already
    // shows reset values; it is never touched by a frame wrap.
    always_comb begin
        vde_d         = pix_ready;
        hsync_d       = busy ? hsync_raw : ~SYNC_POL;
        vsync_d       = busy ? vsync_raw : ~SYNC_POL;
        rgb_d         = (pix_ready && pix_valid) ? pix_data : BLANK_RGB;
        frame_start_d = busy && at_origin;
        underflow_d   = (state_d == ST_IDLE) ? 1'b0
                                             : (underflow_q || (pix_ready && !pix_valid));
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vde_q         <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            rgb_q         <= BLANK_RGB;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vde_q         <= vde_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign vde         = vde_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule
